div_seq: RTL and testbench
==========================

# div_seq

Multi-cycle sequencer and datapath for MIPS DIV/DIVU in the execute stage. It performs a 32-step restoring division and raises `stall_divE` to the hazard unit for the whole computation. It delivers quotient (LO) and remainder (HI) results, and it aborts cleanly on an exception flush.

## Interface
- No parameters; the width is fixed at 32 bits.
- `clk`  in  1  system clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `startE`  in  1  E-stage instruction is DIV/DIVU; held high while that instruction remains in E.
- `signedE`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `opaE`  in  32  dividend (rs value after forwarding).
- `opbE`  in  32  divisor (rt value after forwarding).
- `annulE`  in  1  exception flush; aborts any operation in progress.
- `stall_otherE`  in  1  E is held by a cause other than this block (for example, the instruction-SRAM stall).
- `stall_divE`  out  1  stall request to the hazard unit.
- `div_doneE`  out  1  result valid; a single pulse unless held by `stall_otherE`.
- `quotientE`  out  32  quotient, written to LO.
- `remainderE`  out  32  remainder, written to HI.

## Operation
- The FSM has five states: IDLE, PREP, RUN, FIX, DONE. It has a 5-bit step counter, a 64-bit partial remainder/quotient shift register, captured operand registers, and sign flags `sq` and `sr`.
- **IDLE**
  - If `startE & !annulE`: capture `opaE`, `opbE`, `signedE`, then go to PREP.
  - Otherwise, stay in IDLE.
- **PREP**
  - Set `sq = signed & (a[31]^b[31])` and `sr = signed & a[31]`.
  - Load `|a|` (when signed) into the low half of the shift register, clear the high half, store `|b|`, and clear the counter.
  - Go to RUN.
- **RUN**, one step per cycle:
  - Shift the register left by 1.
  - If `hi >= |b|` (33-bit compare), set `hi -= |b|` and set LSB = 1.
  - Increment the counter. After step 31 (the 32nd step), go to FIX.
- **FIX**
  - Quotient = `sq ? -lo : lo` (32-bit wrap).
  - Remainder = `sr ? -hi : hi`.
  - Register both into `quotientE` and `remainderE`, then go to DONE.
- **DONE**
  - `div_doneE = 1`.
  - If `stall_otherE`, stay in DONE. Otherwise, go to IDLE.
- **Divide by zero:** full latency still applies. In FIX, force `quotientE = 32'hFFFFFFFF` and `remainderE` = captured raw `opaE`, regardless of `signedE`.
- **Overflow** (`0x80000000 / 0xFFFFFFFF`, signed): quotient = `0x80000000`, remainder = 0, with natural wrap and no trap.
- **`annulE`**
  - In any state, the next state is IDLE.
  - `stall_divE` and `div_doneE` are forced to 0 in the same cycle.
  - The result registers are not updated.
- **Operand sampling:** operands are sampled only on the IDLE→PREP edge. Later changes on `opaE`/`opbE` are ignored.
- **Stall output:** `stall_divE = startE & !annulE & (state != DONE)`. This is combinational, so the stall is asserted in the same cycle the instruction reaches E.
- **Result hold:** `quotientE`/`remainderE` hold their value from FIX until the next FIX.

## Timing
- **Reset:** state = IDLE, counter = 0, `quotientE = 0`, `remainderE = 0`, `div_doneE = 0`, `stall_divE = 0`. Reset applies asynchronously, including mid-RUN.
- **Latency:**

  | Cycle | State | `stall_divE` | `div_doneE` |
  |---|---|---|---|
  | C0 (IDLE, `startE` seen) | IDLE | 1 | 0 |
  | C1 | PREP | 1 | 0 |
  | C2–C33 | RUN | 1 | 0 |
  | C34 | FIX | 1 | 0 |
  | C35 | DONE | 0 | 1 |

- **Stall duration:** `stall_divE` is high for exactly 35 cycles (C0–C34) when there is no annul.
- **C35:** results are valid. The pipeline advances at the C35 edge if `stall_otherE = 0`, and the block returns to IDLE at C36.
- **Back-to-back divides:** a following DIV reaching E at C36 starts a new C0 with no bubble.
- **DONE held by `stall_otherE`:** `div_doneE` stays 1 and results stay stable. No restart occurs even though `startE` is still high.
- **`annulE` at cycle k:** `stall_divE` is 0 in cycle k, and the state is IDLE at k+1. A `startE` at k+1 begins a fresh C0.
- **`annulE` and `startE` together in IDLE:** the operation does not start.

## Test plan
- **Unsigned basic:** DIVU 100/7 → `quotientE = 14`, `remainderE = 2`. `stall_divE` is high C0–C34, `div_doneE` is high at C35 only.
- **Signed signs:** DIV -7/2 → q = `0xFFFFFFFD`, r = `0xFFFFFFFF`. DIV 7/-2 → q = `0xFFFFFFFD`, r = 1.
- **Boundaries:**
  - DIV `0x80000000/0xFFFFFFFF` → q = `0x80000000`, r = 0.
  - DIVU `0xFFFFFFFF/1` → q = `0xFFFFFFFF`, r = 0.
  - DIVU 5/0 → q = `0xFFFFFFFF`, r = 5.
- **Annul:** start DIVU 100/7, pulse `annulE` at C10 → `stall_divE = 0` at C10, IDLE at C11. Restart DIVU 9/4 at C12 → q = 2, r = 1 at C12+35, and the old results are never output.
- **Hold:** `stall_otherE = 1` for C35–C37 → `div_doneE` stays high C35–C37 with results stable. The block returns to IDLE at C39 with no second computation.
- **Reset mid-run:** assert `resetn = 0` at C20 → all outputs are 0 immediately. After release, DIVU 50/5 completes normally with q = 10, r = 0.

Source files
------------

// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle DIV/DIVU sequencer for the execute stage
// 32-step restoring divide on magnitudes, sign fix-up at the end, abortable by annulE.
module div_seq (
  input  logic        clk,
  input  logic        resetn,
  input  logic        startE,
  input  logic        signedE,
  input  logic [31:0] opaE,
  input  logic [31:0] opbE,
  input  logic        annulE,
  input  logic        stall_otherE,
  output logic        stall_divE,
  output logic        div_doneE,
  output logic [31:0] quotientE,
  output logic [31:0] remainderE
);

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  state_t      state;
  logic [4:0]  stepCnt;
  logic [63:0] acc;
  logic [31:0] aReg;
  logic [31:0] bReg;
  logic [31:0] absB;
  logic        signReg;
  logic        sq;
  logic        sr;

  logic [31:0] absA;
  logic [31:0] absBNext;
  logic [32:0] shiftHi;
  logic [32:0] diff;
  logic        geB;
  logic [31:0] quotFix;
  logic [31:0] remFix;

  assign absA     = (signReg && aReg[31]) ? (32'd0 - aReg) : aReg;
  assign absBNext = (signReg && bReg[31]) ? (32'd0 - bReg) : bReg;

  // Shifted partial remainder needs 33 bits: it can reach 2*|b|-1 with |b| up to 2^31.
  assign shiftHi = acc[63:31];
  assign diff    = shiftHi - {1'b0, absB};
  assign geB     = shiftHi >= {1'b0, absB};

  assign quotFix = sq ? (32'd0 - acc[31:0]) : acc[31:0];
  assign remFix  = sr ? (32'd0 - acc[63:32]) : acc[63:32];

  // resetn is folded in so both handshakes drop the instant reset asserts.
  assign stall_divE = resetn & startE & ~annulE & (state != DONE);
  assign div_doneE  = resetn & ~annulE & (state == DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      stepCnt    <= 5'd0;
      acc        <= 64'd0;
      aReg       <= 32'd0;
      bReg       <= 32'd0;
      absB       <= 32'd0;
      signReg    <= 1'b0;
      sq         <= 1'b0;
      sr         <= 1'b0;
      quotientE  <= 32'd0;
      remainderE <= 32'd0;
    end else if (annulE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (startE) begin
            aReg    <= opaE;
            bReg    <= opbE;
            signReg <= signedE;
            state   <= PREP;
          end
        end
        PREP: begin
          sq      <= signReg & (aReg[31] ^ bReg[31]);
          sr      <= signReg & aReg[31];
          acc     <= {32'd0, absA};
          absB    <= absBNext;
          stepCnt <= 5'd0;
          state   <= RUN;
        end
        RUN: begin
          if (geB) acc <= {diff[31:0], acc[30:0], 1'b1};
          else     acc <= {acc[62:0], 1'b0};
          stepCnt <= stepCnt + 5'd1;
          if (stepCnt == 5'd31) state <= FIX;
        end
        FIX: begin
          // Divide by zero reports all-ones and the raw dividend, whatever the signedness.
          if (bReg == 32'd0) begin
            quotientE  <= 32'hFFFF_FFFF;
            remainderE <= aReg;
          end else begin
            quotientE  <= quotFix;
            remainderE <= remFix;
          end
          state <= DONE;
        end
        DONE: begin
          if (!stall_otherE) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - scoreboard bench for div_seq
module tb_div_seq;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        startE = 1'b0;
  logic        signedE = 1'b0;
  logic [31:0] opaE = 32'd0;
  logic [31:0] opbE = 32'd0;
  logic        annulE = 1'b0;
  logic        stall_otherE = 1'b0;
  logic        stall_divE;
  logic        div_doneE;
  logic [31:0] quotientE;
  logic [31:0] remainderE;

  int nTests = 0;
  int nFail = 0;
  logic [63:0] expQ[$];
  logic [31:0] lastQ = 32'd0;
  logic [31:0] lastR = 32'd0;

  div_seq dut (
    .clk(clk), .resetn(resetn), .startE(startE), .signedE(signedE),
    .opaE(opaE), .opbE(opbE), .annulE(annulE), .stall_otherE(stall_otherE),
    .stall_divE(stall_divE), .div_doneE(div_doneE),
    .quotientE(quotientE), .remainderE(remainderE)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint la, lb, lq, lr;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (s) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
      lq = la / lb;
      lr = la % lb;
      return {lq[31:0], lr[31:0]};
    end
    return {a / b, a % b};
  endfunction

  // Called just after a rising edge; returns just after the edge that leaves DONE.
  task automatic doDiv(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
    logic [63:0] want;
    opaE = a; opbE = b; signedE = s; startE = 1'b1;
    expQ.push_back(refDiv(a, b, s));
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      nTests++;
      if (stall_divE !== 1'b1 || div_doneE !== 1'b0) begin
        nFail++;
        $display("FAIL busy_c%0d: stall=%b done=%b, required stall=1 done=0", k, stall_divE, div_doneE);
      end
      @(posedge clk); #1;
      if (k == 1) begin opaE = $urandom; opbE = $urandom; signedE = ~s; end
    end
    want = 64'd0;
    stall_otherE = (hold > 0);
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      if (h == 0) begin
        nTests++;
        if (expQ.size() == 0) begin
          nFail++;
          $display("FAIL scoreboard_empty: size=0, required >0");
        end else want = expQ.pop_front();
      end
      nTests++;
      if (div_doneE !== 1'b1 || stall_divE !== 1'b0 || quotientE !== want[63:32] || remainderE !== want[31:0]) begin
        nFail++;
        $display("FAIL done_c%0d a=%h b=%h s=%b: done=%b stall=%b q=%h r=%h, required done=1 stall=0 q=%h r=%h",
                 35 + h, a, b, s, div_doneE, stall_divE, quotientE, remainderE, want[63:32], want[31:0]);
      end
      @(posedge clk); #1;
      if (h + 1 == hold) stall_otherE = 1'b0;
    end
    lastQ = want[63:32];
    lastR = want[31:0];
    startE = 1'b0;
  endtask

  task automatic checkIdle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      nTests++;
      if (div_doneE !== 1'b0 || stall_divE !== 1'b0 || quotientE !== lastQ || remainderE !== lastR) begin
        nFail++;
        $display("FAIL idle_%0d: done=%b stall=%b q=%h r=%h, required done=0 stall=0 q=%h r=%h",
                 k, div_doneE, stall_divE, quotientE, remainderE, lastQ, lastR);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    #2;
    nTests++;
    if (stall_divE !== 1'b0 || div_doneE !== 1'b0 || quotientE !== 32'd0 || remainderE !== 32'd0) begin
      nFail++;
      $display("FAIL reset: stall=%b done=%b q=%h r=%h, required all 0", stall_divE, div_doneE, quotientE, remainderE);
    end
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    lastQ = 32'd0; lastR = 32'd0;
    checkIdle(2);
  endtask

  task automatic test_unsigned_basic;
    doDiv(32'd100, 32'd7, 1'b0, 0);
    checkIdle(2);
  endtask

  task automatic test_signed;
    doDiv(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    doDiv(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    checkIdle(1);
  endtask

  task automatic test_boundaries;
    doDiv(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    doDiv(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    doDiv(32'd5, 32'd0, 1'b0, 0);
    doDiv(32'hFFFF_FFFB, 32'd0, 1'b1, 0);
    checkIdle(1);
  endtask

  task automatic test_annul;
    opaE = 32'd100; opbE = 32'd7; signedE = 1'b0; startE = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      nTests++;
      if (stall_divE !== 1'b1) begin
        nFail++;
        $display("FAIL annul_busy_c%0d: stall=%b, required 1", k, stall_divE);
      end
      @(posedge clk); #1;
    end
    annulE = 1'b1;
    @(negedge clk);
    nTests++;
    if (stall_divE !== 1'b0 || div_doneE !== 1'b0) begin
      nFail++;
      $display("FAIL annul_c10: stall=%b done=%b, required 0 0", stall_divE, div_doneE);
    end
    @(posedge clk); #1;
    annulE = 1'b0; startE = 1'b0;
    checkIdle(1);
    doDiv(32'd9, 32'd4, 1'b0, 0);
    // annul together with start in IDLE must not launch anything
    startE = 1'b1; annulE = 1'b1; opaE = 32'd77; opbE = 32'd3; signedE = 1'b0;
    @(negedge clk);
    nTests++;
    if (stall_divE !== 1'b0) begin
      nFail++;
      $display("FAIL annul_start_idle: stall=%b, required 0", stall_divE);
    end
    @(posedge clk); #1;
    annulE = 1'b0; startE = 1'b0;
    checkIdle(38);
  endtask

  task automatic test_hold;
    doDiv(32'd1000, 32'd3, 1'b0, 3);
    checkIdle(5);
  endtask

  task automatic test_reset_mid_run;
    opaE = 32'd100; opbE = 32'd7; signedE = 1'b0; startE = 1'b1;
    repeat (20) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    nTests++;
    if (stall_divE !== 1'b0 || div_doneE !== 1'b0 || quotientE !== 32'd0 || remainderE !== 32'd0) begin
      nFail++;
      $display("FAIL reset_mid_run: stall=%b done=%b q=%h r=%h, required all 0", stall_divE, div_doneE, quotientE, remainderE);
    end
    @(posedge clk); #1;
    resetn = 1'b1; startE = 1'b0;
    lastQ = 32'd0; lastR = 32'd0;
    checkIdle(2);
    doDiv(32'd50, 32'd5, 1'b0, 0);
    checkIdle(1);
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, b;
    for (int i = 0; i < 5; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i % 2 == 1) b = 32'd0 - b;
      doDiv(a, b, 1'($urandom_range(0, 1)), 0);
    end
    checkIdle(1);
  endtask

  initial begin
    test_reset;
    test_unsigned_basic;
    test_signed;
    test_boundaries;
    test_annul;
    test_hold;
    test_reset_mid_run;
    test_back_to_back;
    nTests++;
    if (expQ.size() != 0) begin
      nFail++;
      $display("FAIL scoreboard_leftover: size=%0d, required 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
